// File: rtl/ascon_sub_layer_ctrl.sv
// ASCON substitution layer sequencer: NB_SBOX sbox columns per cycle.
// x0 occupies state[319:256], x4 state[63:0]; column j = {x0[j],..,x4[j]}.
module ascon_sub_layer_ctrl #(
    parameter int NB_SBOX = 8
) (
    input  logic         clock_i,
    input  logic         resetb_i,
    input  logic         start_i,
    input  logic [319:0] state_i,
    output logic         ready_o,
    output logic         busy_o,
    output logic         done_o,
    output logic [319:0] state_o
);
    localparam int NB_STEP = 64 / NB_SBOX;
    localparam int CW = (NB_STEP > 1) ? $clog2(NB_STEP) : 1;
    localparam logic [CW-1:0] LAST = CW'(NB_STEP - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    if (NB_SBOX < 1 || NB_SBOX > 64 || (NB_SBOX & (NB_SBOX - 1)) != 0)
    begin : g_bad_nb_sbox
        $error("NB_SBOX must be a power of two in 1..64");
    end

    logic [1:0]    fsm_q;
    logic [CW-1:0] cnt_q;
    logic [319:0]  st_q;
    logic [319:0]  st_sub;
    logic [5:0]    col;
    logic [8:0]    idx;
    logic [4:0]    s_in;
    logic [4:0]    s_out;

    // Substitute the NB_SBOX columns selected by cnt_q; all others pass through.
    always_comb begin
        st_sub = st_q;
        col    = '0;
        idx    = '0;
        s_in   = '0;
        s_out  = '0;
        for (int k = 0; k < NB_SBOX; k++) begin
            col = 6'((int'(cnt_q) * NB_SBOX) + k);
            for (int i = 0; i < 5; i++) begin
                idx         = 9'(64 * (4 - i)) + {3'b000, col};
                s_in[4 - i] = st_q[idx];
            end
            s_out = SBOX[s_in];
            for (int i = 0; i < 5; i++) begin
                idx         = 9'(64 * (4 - i)) + {3'b000, col};
                st_sub[idx] = s_out[4 - i];
            end
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm_q <= S_IDLE;
            cnt_q <= '0;
            st_q  <= '0;
        end else begin
            case (fsm_q)
                S_IDLE: begin
                    if (start_i) begin
                        st_q  <= state_i;
                        cnt_q <= '0;
                        fsm_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    st_q <= st_sub;
                    if (cnt_q == LAST) begin
                        cnt_q <= '0;
                        fsm_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    fsm_q <= S_IDLE;
                end
                default: begin
                    fsm_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ready_o = (fsm_q == S_IDLE);
    assign busy_o  = (fsm_q == S_RUN);
    assign done_o  = (fsm_q == S_DONE);
    assign state_o = st_q;

endmodule
